// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single main-memory port between the I-cache and D-cache.
//   Round-robin between the two requesters, one transaction in flight at a
//   time, request fields captured at grant. A watchdog ends a transaction
//   that memory never acknowledges and flags it with an error.
//
// Ports
//   clk, reset              clock, synchronous active-low reset
//   ic_addr/en/we/di        I-cache request (en held until ic_ack)
//   ic_do/ack/err           I-cache completion: data, 1-cycle pulse, timeout flag
//   dc_addr/en/we/di        D-cache request (en held until dc_ack)
//   dc_do/ack/err           D-cache completion: data, 1-cycle pulse, timeout flag
//   mem_addr/en/we/di       main-memory request, held stable while busy
//   mem_ack, mem_do         main-memory completion and read data
module mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ic_addr,
  input  logic        ic_en,
  input  logic        ic_we,
  input  logic [31:0] ic_di,
  output logic [31:0] ic_do,
  output logic        ic_ack,
  output logic        ic_err,
  input  logic [15:0] dc_addr,
  input  logic        dc_en,
  input  logic        dc_we,
  input  logic [31:0] dc_di,
  output logic [31:0] dc_do,
  output logic        dc_ack,
  output logic        dc_err,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_di,
  input  logic        mem_ack,
  input  logic [31:0] mem_do
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  // Last winner; also identifies the requester that owns the transaction
  // in flight, since it is updated at grant.
  logic             last_dc;
  logic [CNT_W-1:0] watchdog;

  logic grant_ic;
  logic grant_dc;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (ic_en && (!dc_en || last_dc))
      grant_ic = 1'b1;
    else if (dc_en)
      grant_dc = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      last_dc  <= 1'b1;
      watchdog <= '0;
      mem_addr <= '0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_di   <= '0;
      ic_do    <= '0;
      ic_ack   <= 1'b0;
      ic_err   <= 1'b0;
      dc_do    <= '0;
      dc_ack   <= 1'b0;
      dc_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ic) begin
            mem_addr <= ic_addr;
            mem_we   <= ic_we;
            mem_di   <= ic_di;
            mem_en   <= 1'b1;
            watchdog <= '0;
            last_dc  <= 1'b0;
            state    <= BUSY;
          end else if (grant_dc) begin
            mem_addr <= dc_addr;
            mem_we   <= dc_we;
            mem_di   <= dc_di;
            mem_en   <= 1'b1;
            watchdog <= '0;
            last_dc  <= 1'b1;
            state    <= BUSY;
          end
        end

        BUSY: begin
          // A real acknowledge wins over a coincident timeout.
          if (mem_ack) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (last_dc) begin
              dc_do  <= mem_do;
              dc_ack <= 1'b1;
              dc_err <= 1'b0;
            end else begin
              ic_do  <= mem_do;
              ic_ack <= 1'b1;
              ic_err <= 1'b0;
            end
            state <= DONE;
          end else if (watchdog == WD_LAST) begin
            mem_en <= 1'b0;
            if (last_dc) begin
              dc_do  <= '0;
              dc_ack <= 1'b1;
              dc_err <= 1'b1;
            end else begin
              ic_do  <= '0;
              ic_ack <= 1'b1;
              ic_err <= 1'b1;
            end
            state <= DONE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        DONE: begin
          // One-cycle buffer so the finished requester's en, still high in
          // this cycle, is never mistaken for a new request.
          ic_ack <= 1'b0;
          ic_err <= 1'b0;
          dc_ack <= 1'b0;
          dc_err <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] ic_addr;
  logic        ic_en;
  logic        ic_we;
  logic [31:0] ic_di;
  logic [31:0] ic_do;
  logic        ic_ack;
  logic        ic_err;
  logic [15:0] dc_addr;
  logic        dc_en;
  logic        dc_we;
  logic [31:0] dc_di;
  logic [31:0] dc_do;
  logic        dc_ack;
  logic        dc_err;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_di;
  logic        mem_ack;
  logic [31:0] mem_do;

  int total;
  int passed;

  mem_arbiter #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset),
    .ic_addr(ic_addr), .ic_en(ic_en), .ic_we(ic_we), .ic_di(ic_di),
    .ic_do(ic_do), .ic_ack(ic_ack), .ic_err(ic_err),
    .dc_addr(dc_addr), .dc_en(dc_en), .dc_we(dc_we), .dc_di(dc_di),
    .dc_do(dc_do), .dc_ack(dc_ack), .dc_err(dc_err),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_di(mem_di),
    .mem_ack(mem_ack), .mem_do(mem_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "global timeout");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mem_en(output bit ok);
    for (int k = 0; k < 20 && mem_en !== 1'b1; k++) tick();
    ok = (mem_en === 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; ic_en = 1'b0; dc_en = 1'b0; ic_we = 1'b0; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0; ic_di = '0; dc_di = '0;
    mem_ack = 1'b0; mem_do = '0;
    tick(); tick();
    total++; if ({mem_en, mem_we, mem_addr, mem_di} !== 50'h0)
      $display("FAIL reset_mem: got %h want 0", {mem_en, mem_we, mem_addr, mem_di}); else passed++;
    total++; if ({ic_ack, ic_err, ic_do, dc_ack, dc_err, dc_do} !== 68'h0)
      $display("FAIL reset_req: got %h want 0", {ic_ack, ic_err, ic_do, dc_ack, dc_err, dc_do}); else passed++;
    reset = 1'b1;
    tick();
    total++; if (mem_en !== 1'b0)
      $display("FAIL reset_idle_mem_en: got %b want 0", mem_en); else passed++;
  endtask

  task automatic test_ic_read();
    ic_addr = 16'h1234; ic_we = 1'b0; ic_en = 1'b1;
    tick();
    total++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h1234})
      $display("FAIL ic_read_req: got en=%b we=%b addr=%h want en=1 we=0 addr=1234", mem_en, mem_we, mem_addr); else passed++;
    mem_ack = 1'b1; mem_do = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    total++; if ({ic_ack, ic_err, dc_ack} !== 3'b100)
      $display("FAIL ic_read_ack: got ic_ack=%b ic_err=%b dc_ack=%b want 1 0 0", ic_ack, ic_err, dc_ack); else passed++;
    total++; if (ic_do !== 32'hDEADBEEF)
      $display("FAIL ic_read_data: got %h want deadbeef", ic_do); else passed++;
    total++; if (mem_en !== 1'b0)
      $display("FAIL ic_read_mem_en_drop: got %b want 0", mem_en); else passed++;
    ic_en = 1'b0;
    tick();
    total++; if ({ic_ack, ic_do} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL ic_read_pulse_hold: got ack=%b do=%h want ack=0 do=deadbeef", ic_ack, ic_do); else passed++;
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    ic_addr = 16'h0100; ic_we = 1'b0; ic_di = 32'h0;
    dc_addr = 16'h8004; dc_we = 1'b1; dc_di = 32'hCAFEF00D;
    ic_en = 1'b1; dc_en = 1'b1;
    tick();
    total++; if ({mem_en, mem_addr, mem_we} !== {1'b1, 16'h0100, 1'b0})
      $display("FAIL tie_first_ic: got en=%b addr=%h we=%b want en=1 addr=0100 we=0", mem_en, mem_addr, mem_we); else passed++;
    mem_ack = 1'b1; mem_do = 32'h0000_1111;
    tick();
    mem_ack = 1'b0;
    total++; if ({ic_ack, dc_ack} !== 2'b10)
      $display("FAIL tie_ic_ack: got ic=%b dc=%b want 1 0", ic_ack, dc_ack); else passed++;
    ic_en = 1'b0;
    tick();
    total++; if (mem_en !== 1'b0)
      $display("FAIL tie_done_no_mem: got %b want 0", mem_en); else passed++;
    tick();
    total++; if ({mem_en, mem_addr, mem_we, mem_di} !== {1'b1, 16'h8004, 1'b1, 32'hCAFEF00D})
      $display("FAIL tie_dc_grant: got en=%b addr=%h we=%b di=%h want 1 8004 1 cafef00d", mem_en, mem_addr, mem_we, mem_di); else passed++;
    mem_ack = 1'b1; mem_do = 32'h0000_0011;
    tick();
    mem_ack = 1'b0;
    total++; if ({dc_ack, ic_ack, dc_err, dc_do} !== {3'b100, 32'h11})
      $display("FAIL tie_dc_ack: got dc_ack=%b ic_ack=%b err=%b do=%h want 1 0 0 00000011", dc_ack, ic_ack, dc_err, dc_do); else passed++;
    dc_en = 1'b0; dc_we = 1'b0;
    tick(); tick();
  endtask

  task automatic test_alternate();
    bit ok;
    bit is_dc;
    ic_addr = 16'h0AAA; dc_addr = 16'h0BBB; ic_we = 1'b0; dc_we = 1'b0;
    ic_en = 1'b1; dc_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      is_dc = (i % 2) == 1;
      wait_mem_en(ok);
      total++; if (!ok)
        $display("FAIL alt_grant_%0d: got mem_en=%b want 1", i, mem_en); else passed++;
      total++; if (mem_addr !== (is_dc ? 16'h0BBB : 16'h0AAA))
        $display("FAIL alt_order_%0d: got addr=%h want %h", i, mem_addr, is_dc ? 16'h0BBB : 16'h0AAA); else passed++;
      mem_ack = 1'b1; mem_do = 32'h100 + i;
      tick();
      mem_ack = 1'b0;
      total++; if ({ic_ack, dc_ack} !== {!is_dc, is_dc})
        $display("FAIL alt_ack_%0d: got ic=%b dc=%b want %b %b", i, ic_ack, dc_ack, !is_dc, is_dc); else passed++;
      if (is_dc) dc_en = 1'b0; else ic_en = 1'b0;
      tick();
      ic_en = 1'b1; dc_en = 1'b1;
    end
    ic_en = 1'b0; dc_en = 1'b0;
    // Last grant above was DC, so a late IC-only request may still be
    // pending in IDLE only if en were high; both are low now.
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n;
    dc_addr = 16'h2222; dc_we = 1'b0; dc_en = 1'b1;
    tick();
    total++; if (mem_en !== 1'b1)
      $display("FAIL to_grant: got %b want 1", mem_en); else passed++;
    n = 0;
    for (int k = 1; k <= 100 && n == 0; k++) begin
      tick();
      if (dc_ack === 1'b1) n = k;
    end
    total++; if (n !== 64)
      $display("FAIL to_cycles: got %0d want 64", n); else passed++;
    total++; if ({dc_err, dc_do, mem_en, ic_ack} !== {1'b1, 32'h0, 1'b0, 1'b0})
      $display("FAIL to_result: got err=%b do=%h mem_en=%b ic_ack=%b want 1 0 0 0", dc_err, dc_do, mem_en, ic_ack); else passed++;
    dc_en = 1'b0;
    tick();
    total++; if ({dc_ack, dc_err} !== 2'b00)
      $display("FAIL to_err_pulse: got ack=%b err=%b want 0 0", dc_ack, dc_err); else passed++;
    tick();
    ic_addr = 16'h2468; ic_en = 1'b1;
    tick();
    mem_ack = 1'b1; mem_do = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    total++; if ({ic_ack, ic_err, ic_do} !== {2'b10, 32'h0BADF00D})
      $display("FAIL to_recover: got ack=%b err=%b do=%h want 1 0 0badf00d", ic_ack, ic_err, ic_do); else passed++;
    ic_en = 1'b0;
    tick(); tick();
  endtask

  task automatic test_ack_at_timeout();
    ic_addr = 16'h3333; ic_en = 1'b1;
    tick();
    for (int k = 1; k <= 63; k++) tick();
    total++; if ({mem_en, ic_ack} !== 2'b10)
      $display("FAIL edge_still_busy: got mem_en=%b ic_ack=%b want 1 0", mem_en, ic_ack); else passed++;
    mem_ack = 1'b1; mem_do = 32'h5;
    tick();
    mem_ack = 1'b0;
    total++; if ({ic_ack, ic_err, ic_do} !== {2'b10, 32'h5})
      $display("FAIL edge_ack_wins: got ack=%b err=%b do=%h want 1 0 00000005", ic_ack, ic_err, ic_do); else passed++;
    ic_en = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_busy();
    int acks;
    dc_addr = 16'h4444; dc_we = 1'b1; dc_di = 32'h1234_5678; dc_en = 1'b1;
    tick();
    total++; if (mem_en !== 1'b1)
      $display("FAIL rst_busy_grant: got %b want 1", mem_en); else passed++;
    reset = 1'b0;
    tick();
    total++; if ({mem_en, mem_we, mem_addr, mem_di, ic_ack, ic_err, ic_do, dc_ack, dc_err, dc_do} !== 118'h0)
      $display("FAIL rst_busy_clear: got %h want 0", {mem_en, mem_we, mem_addr, mem_di, ic_ack, ic_err, ic_do, dc_ack, dc_err, dc_do}); else passed++;
    dc_en = 1'b0; dc_we = 1'b0;
    acks = 0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ic_ack === 1'b1 || dc_ack === 1'b1 || mem_en === 1'b1) acks++;
    end
    total++; if (acks !== 0)
      $display("FAIL rst_no_ack: got %0d activity cycles want 0", acks); else passed++;
    ic_addr = 16'h5555; ic_we = 1'b0; ic_en = 1'b1;
    tick();
    total++; if ({mem_en, mem_addr} !== {1'b1, 16'h5555})
      $display("FAIL rst_fresh_grant: got en=%b addr=%h want 1 5555", mem_en, mem_addr); else passed++;
    mem_ack = 1'b1; mem_do = 32'h77;
    tick();
    mem_ack = 1'b0;
    total++; if ({ic_ack, ic_err, ic_do} !== {2'b10, 32'h77})
      $display("FAIL rst_fresh_done: got ack=%b err=%b do=%h want 1 0 00000077", ic_ack, ic_err, ic_do); else passed++;
    ic_en = 1'b0;
    tick(); tick();
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_ic_read();
    test_tie();
    test_alternate();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
